// File: rtl/fifo_flag_checker.sv
// rtl/fifo_flag_checker.sv - reference checker for FIFO status flags, occupancy and statistics
//
// Purpose: tracks a reference occupancy from the write/read requests a FIFO sees,
// checks the FIFO's status flags against it every cycle, and keeps request statistics.
// Optional macro FIFO_CHK_DATA_EN adds a shadow memory that checks read data order.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_enb, rd_enb            requests presented to the FIFO
//   wr_data, rd_data          write data, registered read data (used only with FIFO_CHK_DATA_EN)
//   fifo_*                    status flags of the FIFO under check
//   clr_stats                 zeroes the four statistics counters
//   model_count               reference occupancy
//   wr/rd/ovr/udr_count       accepted writes, accepted reads, rejected writes, rejected reads
//   err_valid                 pulse for each cycle that held a mismatch
//   err_sticky, err_code      first-mismatch flag and its code (1..7)
module fifo_flag_checker #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int CNT_W     = 16,
  localparam int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enb,
  input  logic              rd_enb,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic              fifo_almost_full,
  input  logic              fifo_almost_empty,
  input  logic              fifo_overrun,
  input  logic              fifo_underrun,
  input  logic              clr_stats,
  output logic [OCC_W-1:0]  model_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  ovr_count,
  output logic [CNT_W-1:0]  udr_count,
  output logic              err_valid,
  output logic              err_sticky,
  output logic [2:0]        err_code
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;
  logic [CNT_W-1:0]  udr_cnt_q, udr_cnt_d;
  logic              ovr_pend_q, udr_pend_q;
  logic              err_valid_q, err_valid_d;
  logic              err_sticky_q, err_sticky_d;
  logic [2:0]        err_code_q, err_code_d;

  logic              acc_wr, acc_rd, rej_wr, rej_rd;
  logic              chk_all;
  logic              data_mism;
  logic [7:1]        mism;
  logic [2:0]        code_now;

  // A write at full is rejected even if a read frees a slot in the same cycle.
  always_comb begin
    acc_wr = wr_enb && (count_q != DEPTH_C);
    acc_rd = rd_enb && (count_q != '0);
    rej_wr = wr_enb && !acc_wr;
    rej_rd = rd_enb && !acc_rd;
  end

`ifdef FIFO_CHK_DATA_EN
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [DATA_W-1:0] exp_data_q;
  logic              rd_chk_q;

  always_ff @(posedge clk) begin
    if (acc_wr) shadow_q[wptr_q] <= wr_data;
  end

  // The expected word is captured at the accepted read and compared when the
  // FIFO's registered rd_data appears one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      exp_data_q <= '0;
      rd_chk_q   <= 1'b0;
    end else begin
      rd_chk_q <= acc_rd;
      if (acc_wr) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      if (acc_rd) begin
        exp_data_q <= shadow_q[rptr_q];
        rptr_q     <= (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      end
    end
  end

  assign data_mism = rd_chk_q && (rd_data != exp_data_q);
`else
  logic unused_data;
  assign unused_data = ^{wr_data, rd_data};
  assign data_mism   = 1'b0;
`endif

  // Full checking starts in the same cycle as the first request leaves IDLE.
  always_comb begin
    chk_all = (state_q != IDLE) || wr_enb || rd_enb;
    mism[1] = fifo_full  != (count_q == DEPTH_C);
    mism[2] = fifo_empty != (count_q == '0);
    mism[3] = chk_all && (fifo_almost_full  != (int'(count_q) >= AF_THRESH));
    mism[4] = chk_all && (fifo_almost_empty != (int'(count_q) <= AE_THRESH));
    mism[5] = chk_all && (fifo_overrun  != ovr_pend_q);
    mism[6] = chk_all && (fifo_underrun != udr_pend_q);
    mism[7] = chk_all && data_mism;
    code_now = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (mism[i]) code_now = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|mism) state_d = LOCKED;
               else if (wr_enb || rd_enb) state_d = RUN;
      RUN:     if (|mism) state_d = LOCKED;
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({acc_wr, acc_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Saturating counters; a clear wins over an increment in the same cycle.
    wr_cnt_d  = wr_cnt_q  + CNT_W'(acc_wr && (wr_cnt_q  != '1));
    rd_cnt_d  = rd_cnt_q  + CNT_W'(acc_rd && (rd_cnt_q  != '1));
    ovr_cnt_d = ovr_cnt_q + CNT_W'(rej_wr && (ovr_cnt_q != '1));
    udr_cnt_d = udr_cnt_q + CNT_W'(rej_rd && (udr_cnt_q != '1));
    if (clr_stats) begin
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      ovr_cnt_d = '0;
      udr_cnt_d = '0;
    end

    err_valid_d  = |mism;
    err_sticky_d = err_sticky_q || (|mism);
    err_code_d   = (!err_sticky_q && (|mism)) ? code_now : err_code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      ovr_cnt_q    <= '0;
      udr_cnt_q    <= '0;
      ovr_pend_q   <= 1'b0;
      udr_pend_q   <= 1'b0;
      err_valid_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      ovr_cnt_q    <= ovr_cnt_d;
      udr_cnt_q    <= udr_cnt_d;
      ovr_pend_q   <= rej_wr;
      udr_pend_q   <= rej_rd;
      err_valid_q  <= err_valid_d;
      err_sticky_q <= err_sticky_d;
      err_code_q   <= err_code_d;
    end
  end

  assign model_count = count_q;
  assign wr_count    = wr_cnt_q;
  assign rd_count    = rd_cnt_q;
  assign ovr_count   = ovr_cnt_q;
  assign udr_count   = udr_cnt_q;
  assign err_valid   = err_valid_q;
  assign err_sticky  = err_sticky_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_fifo_flag_checker.sv
// tb/tb_fifo_flag_checker.sv - directed self-checking bench for fifo_flag_checker
module tb_fifo_flag_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_enb, rd_enb;
  logic [7:0]  wr_data, rd_data;
  logic        fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic        fifo_overrun, fifo_underrun;
  logic        clr_stats;
  logic [4:0]  model_count;
  logic [15:0] wr_count, rd_count, ovr_count, udr_count;
  logic        err_valid, err_sticky;
  logic [2:0]  err_code;

  int n_chk  = 0;
  int n_fail = 0;

  // Behaviour of a correctly working 16-deep FIFO, used to drive its flags.
  int         occ = 0;
  bit         pend_ovr = 0, pend_udr = 0;
  logic [7:0] fq[$];
  logic [7:0] rd_next = 8'h00;

  always #5 clk = ~clk;

  fifo_flag_checker dut (
    .clk(clk), .rst(rst),
    .wr_enb(wr_enb), .rd_enb(rd_enb),
    .wr_data(wr_data), .rd_data(rd_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
    .fifo_overrun(fifo_overrun), .fifo_underrun(fifo_underrun),
    .clr_stats(clr_stats),
    .model_count(model_count),
    .wr_count(wr_count), .rd_count(rd_count),
    .ovr_count(ovr_count), .udr_count(udr_count),
    .err_valid(err_valid), .err_sticky(err_sticky), .err_code(err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [7:0] wd);
    wr_enb            = wr;
    rd_enb            = rd;
    wr_data           = wd;
    clr_stats         = 1'b0;
    fifo_full         = (occ == 16);
    fifo_empty        = (occ == 0);
    fifo_almost_full  = (occ >= 14);
    fifo_almost_empty = (occ <= 2);
    fifo_overrun      = pend_ovr;
    fifo_underrun     = pend_udr;
    rd_data           = rd_next;
  endtask

  task automatic tick();
    bit aw, ar;
    aw = wr_enb && (occ < 16);
    ar = rd_enb && (occ > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      occ = 0; pend_ovr = 0; pend_udr = 0; fq.delete(); rd_next = 8'h00;
    end else begin
      pend_ovr = wr_enb && !aw;
      pend_udr = rd_enb && !ar;
      if (ar) rd_next = fq.pop_front();
      if (aw) fq.push_back(wr_data);
      occ = occ + int'(aw) - int'(ar);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 8'h00);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00);
    tick();
    tick();
    chk("rst_model_count", model_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_ovr_count", ovr_count, 0);
    chk("rst_udr_count", udr_count, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_err_code", err_code, 0);
    rst = 1'b0;

    // Fill with 0x00..0x0F, flags correct throughout
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i));
      tick();
      chk("fill_err_valid", err_valid, 0);
    end
    chk("fill_model_count", model_count, 16);
    chk("fill_wr_count", wr_count, 16);
    chk("fill_err_sticky", err_sticky, 0);

    // Write + read while full: read accepted, write rejected
    drive(1, 1, 8'hEE);
    tick();
    chk("full_wrrd_model_count", model_count, 15);
    chk("full_wrrd_ovr_count", ovr_count, 1);
    chk("full_wrrd_rd_count", rd_count, 1);
    chk("full_wrrd_wr_count", wr_count, 16);
    drive(0, 0, 8'h00);               // fifo_overrun high here is expected
    tick();
    chk("ovr_expected_err_valid", err_valid, 0);
    chk("ovr_expected_err_sticky", err_sticky, 0);
    drive(0, 0, 8'h00);
    fifo_overrun = 1'b1;              // one cycle too long
    tick();
    chk("ovr_extra_err_valid", err_valid, 1);
    chk("ovr_extra_err_code", err_code, 5);

    // Underrun not reported by the FIFO
    do_reset();
    drive(0, 1, 8'h00);
    tick();
    chk("udr_req_udr_count", udr_count, 1);
    chk("udr_req_model_count", model_count, 0);
    chk("udr_req_err_valid", err_valid, 0);
    drive(0, 0, 8'h00);
    fifo_underrun = 1'b0;
    tick();
    chk("udr_miss_err_valid", err_valid, 1);
    chk("udr_miss_err_sticky", err_sticky, 1);
    chk("udr_miss_err_code", err_code, 6);
    drive(0, 0, 8'h00);
    tick();
    chk("udr_after_err_valid", err_valid, 0);
    chk("udr_after_err_sticky", err_sticky, 1);

    // Reset drops a pending underrun expectation
    do_reset();
    drive(0, 1, 8'h00);
    tick();
    rst = 1'b1;
    drive(0, 0, 8'h00);
    fifo_underrun = 1'b0;
    tick();
    rst = 1'b0;
    drive(1, 0, 8'h01);
    tick();
    chk("rst_pend_err_valid", err_valid, 0);
    chk("rst_pend_err_sticky", err_sticky, 0);
    chk("rst_pend_udr_count", udr_count, 0);

    // Count 13: wrong full plus wrong almost_empty -> lowest code wins, then frozen
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1, 0, 8'(i));
      tick();
    end
    chk("c13_model_count", model_count, 13);
    chk("c13_err_sticky", err_sticky, 0);
    drive(0, 0, 8'h00);
    fifo_full = 1'b1;
    fifo_almost_empty = 1'b1;
    tick();
    chk("c13_err_valid", err_valid, 1);
    chk("c13_err_code", err_code, 1);
    drive(0, 0, 8'h00);
    fifo_empty = 1'b1;
    tick();
    chk("c13_second_err_valid", err_valid, 1);
    chk("c13_second_err_code", err_code, 1);
    drive(0, 0, 8'h00);
    tick();
    chk("c13_clean_err_valid", err_valid, 0);
    chk("c13_clean_err_code", err_code, 1);

    // IDLE checks only full/empty
    do_reset();
    drive(0, 0, 8'h00);
    fifo_almost_full = 1'b1;
    fifo_almost_empty = 1'b0;
    fifo_overrun = 1'b1;
    tick();
    chk("idle_gated_err_valid", err_valid, 0);
    chk("idle_gated_err_sticky", err_sticky, 0);
    drive(0, 0, 8'h00);
    fifo_empty = 1'b0;
    tick();
    chk("idle_empty_err_valid", err_valid, 1);
    chk("idle_empty_err_code", err_code, 2);

    // Read data 0x5A after writing 0xA5
    do_reset();
    drive(1, 0, 8'hA5);
    tick();
    drive(0, 1, 8'h00);
    tick();
    drive(0, 0, 8'h00);
    rd_data = 8'h5A;
    tick();
`ifdef FIFO_CHK_DATA_EN
    chk("data_err_valid", err_valid, 1);
    chk("data_err_code", err_code, 7);
`else
    chk("data_err_valid", err_valid, 0);
    chk("data_err_sticky", err_sticky, 0);
`endif

    // Counter saturation and clr_stats
    do_reset();
    drive(1, 0, 8'h33);
    tick();
    for (int i = 0; i < 65534; i++) begin
      drive(1, 1, 8'h33);
      tick();
    end
    chk("sat_wr_count", wr_count, 16'hFFFF);
    chk("sat_model_count", model_count, 1);
    chk("sat_err_sticky", err_sticky, 0);
    drive(1, 1, 8'h33);
    tick();
    chk("sat_hold_wr_count", wr_count, 16'hFFFF);
    chk("sat_rd_count", rd_count, 16'hFFFF);
    drive(0, 0, 8'h00);
    clr_stats = 1'b1;
    tick();
    chk("clr_wr_count", wr_count, 0);
    chk("clr_rd_count", rd_count, 0);
    chk("clr_model_count", model_count, 1);
    drive(1, 0, 8'h44);
    clr_stats = 1'b1;
    tick();
    chk("clr_lost_wr_count", wr_count, 0);
    chk("clr_lost_model_count", model_count, 2);
    drive(0, 0, 8'h00);
    tick();
    chk("clr_err_sticky", err_sticky, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_flag_checker.md
FIFO_FLAG_CHECKER -- requirements
Module: fifo_flag_checker

Interface
REQ-001 Parameter DATA_W, default 8, data width of the FIFO under check.
REQ-002 Parameter DEPTH, default 16, FIFO depth in entries (>=4).
REQ-003 Parameter AF_THRESH, default DEPTH-2, almost-full when occupancy >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2, almost-empty when occupancy <= AE_THRESH.
REQ-005 Parameter CNT_W, default 16, width of statistics counters.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 wr_enb / rd_enb  input  1 each  write/read request seen by FIFO.
REQ-009 wr_data / rd_data  input  DATA_W each  FIFO write data / registered read data.
REQ-010 fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty, fifo_overrun, fifo_underrun  input  1 each  DUT status flags.
REQ-011 clr_stats  input  1  clears statistics counters only.
REQ-012 model_count  output  $clog2(DEPTH+1)  reference occupancy.
REQ-013 wr_count, rd_count, ovr_count, udr_count  output  CNT_W each  accepted writes, accepted reads, rejected writes, rejected reads.
REQ-014 err_valid  output  1  one-cycle pulse per cycle with any mismatch.
REQ-015 err_sticky  output  1  set on first mismatch, held until reset.
REQ-016 err_code  output  3  code of first mismatch, frozen once err_sticky set.

Function
REQ-017 Accepted write = wr_enb && model_count<DEPTH; accepted read = rd_enb && model_count>0; write while full rejected even with simultaneous read.
REQ-018 model_count: +1 on write only, -1 on read only, unchanged on both or neither; never wraps.
REQ-019 Each cycle in RUN/LOCKED, compare DUT flags to model_count register: full==(count==DEPTH), empty==(count==0), almost_full==(count>=AF_THRESH), almost_empty==(count<=AE_THRESH).
REQ-020 Expected fifo_overrun = registered rejected-write, expected fifo_underrun = registered rejected-read (high exactly one cycle after the rejected request).
REQ-021 Error codes: 1 full, 2 empty, 3 almost_full, 4 almost_empty, 5 overrun, 6 underrun, 7 data; simultaneous mismatches report lowest code.
REQ-022 err_valid registered: asserts the cycle after the mismatched sample, for one cycle per mismatching cycle.
REQ-023 FSM states IDLE, RUN, LOCKED; IDLE->RUN on first wr_enb or rd_enb (checks start that same cycle); RUN->LOCKED on first mismatch; LOCKED exits only by reset.
REQ-024 In IDLE only fifo_empty and fifo_full are checked; no error outputs other than from these.
REQ-025 Counters increment per REQ-017 classification, saturate at all-ones, continue in LOCKED.
REQ-026 clr_stats zeroes the four counters next edge; model, FSM and error state unaffected; increment in same cycle is lost.

Reset
REQ-027 On rst high at an edge: FSM=IDLE, model_count=0, all counters 0, err_valid=0, err_sticky=0, err_code=0, scoreboard pointers 0.
REQ-028 Reset mid-operation discards all in-flight expectations, including a pending overrun/underrun or read-data compare.

Configuration
REQ-029 Macro FIFO_CHK_DATA_EN compiles in a DEPTH x DATA_W shadow memory storing accepted wr_data in order.
REQ-030 With FIFO_CHK_DATA_EN: rd_data compared one cycle after each accepted read against oldest shadow entry; inequality = code 7.
REQ-031 Without FIFO_CHK_DATA_EN: no shadow memory, rd_data ignored, code 7 never raised.

Verification
REQ-032 Reset, DEPTH=16, 16 writes 0x00..0x0F, flags correct -> model_count=16, wr_count=16, err_sticky=0.
REQ-033 Full FIFO, wr_enb with rd_enb one cycle -> model_count 15, ovr_count 1, fifo_overrun expected high next cycle.
REQ-034 Empty FIFO, rd_enb one cycle, DUT fifo_underrun held low -> err_valid pulse, err_sticky=1, err_code=6.
REQ-035 Count=13, DUT fifo_almost_full low and fifo_full wrongly high same cycle -> err_code=1, later mismatches leave err_code=1.
REQ-036 FIFO_CHK_DATA_EN defined, write 0xA5 then read returns 0x5A -> err_code=7; macro undefined -> no error.
REQ-037 wr_count=0xFFFF then write -> stays 0xFFFF; clr_stats -> 0 next cycle, model_count unchanged.
